// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier: one partial product per cycle,
// fixed WIDTH-cycle latency, registered product with a one-cycle done pulse.
module shift_add_mult #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               busy_next;
  logic               done_next;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   pp;
  logic               b_bit;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  // Mask-and-reduce picks B_r[cnt] without an out-of-range index when CNT_W is wider
  assign b_bit   = |(b_r & (WIDTH'(1) << cnt));
  assign pp      = a_r & {WIDTH{b_bit}};
  assign acc_sum = acc + ((2*WIDTH)'(pp) << cnt);

  // State and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags track the state being entered so they line up with it
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    if (state_next == RUN)  busy_next = 1'b1;
    if (state_next == DONE) done_next = 1'b1;
  end

  // Operand latch, accumulator and iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      if (last) product <= acc_sum;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at WIDTH=32 and WIDTH=4.
module tb_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, busy, done;
  logic [31:0] a, b;
  logic [63:0] product;
  logic        rst4_n, start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] p;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  exp_t e32, e4;

  shift_add_mult #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  shift_add_mult #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop and compare on every done pulse, including the cycle it arrives on
  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) check("unexp_done32", 1, 0);
      else begin
        e32 = q32.pop_front();
        check("prod32", product, e32.p);
        check("lat32", cyc, e32.due);
      end
    end
    if (done4) begin
      if (q4.size() == 0) check("unexp_done4", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("prod4", 64'(product4), e4.p);
        check("lat4", cyc, e4.due);
      end
    end
  end

  // Called at a negedge; accept happens at the following posedge
  task automatic op32(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    start = 1'b1;
    q32.push_back('{p: 64'(x) * 64'(y), due: cyc + 33});
    @(negedge clk);
    start = 1'b0;
  endtask

  int n;
  int t0;
  logic [7:0] v;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    rst4_n = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    check("rst_prod4", product4, 0);
    rst_n = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk);

    // 7*6 with busy length and return to idle
    op32(32'd7, 32'd6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("busy_len", n, 32);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("hold42", product, 64'd42);

    // all-ones corner
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    check("ones", product, 64'hFFFF_FFFE_0000_0001);

    // start held high: second accept only from DONE, 33 cycles apart
    t0 = cyc;
    a = 32'd3; b = 32'd5; start = 1'b1;
    q32.push_back('{p: 64'd15, due: t0 + 33});
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (cyc == t0 + 33) begin
        a = 32'd10; b = 32'd10;
        q32.push_back('{p: 64'd100, due: cyc + 33});
      end else begin
        a = $urandom; b = $urandom;
      end
      if (cyc == t0 + 20) check("busy_held", busy, 1);
      if (cyc == t0 + 40) start = 1'b0;
    end
    start = 1'b0;
    repeat (30) @(negedge clk);

    // operands changed mid-RUN
    op32(32'd123456, 32'd789);
    repeat (5) @(negedge clk);
    a = $urandom; b = $urandom;
    repeat (40) @(negedge clk);

    // reset at RUN cycle 10, then immediate restart
    t0 = cyc;
    a = 32'd55; b = 32'd66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_prod", product, 0);
    rst_n = 1'b1;
    op32(32'd9, 32'd9);
    repeat (40) @(negedge clk);

    // b=0, a=0 and random pairs
    op32(32'hDEAD_BEEF, 32'd0);
    repeat (34) @(negedge clk);
    op32(32'd0, 32'hCAFE_F00D);
    repeat (34) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      op32($urandom, $urandom);
      repeat (34) @(negedge clk);
    end

    // WIDTH=4: every operand pair in a scrambled order
    for (int i = 0; i < 256; i++) begin
      v = 8'((i * 37 + 11) % 256);
      a4 = v[7:4];
      b4 = v[3:0];
      start4 = 1'b1;
      q4.push_back('{p: 64'(a4) * 64'(b4), due: cyc + 5});
      @(negedge clk);
      start4 = 1'b0;
      repeat (5) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("q32_empty", q32.size(), 0);
    check("q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
